dl_rr_arb4: RTL
===============

# dl_rr_arb4

Four-requester round-robin arbiter that shares one downstream consumer between four valid/ready producers. Each cycle it selects a winner with a rotating priority and steers that requester's payload through a 4:1 data select into a single-entry registered output stage. It sits in front of any shared single-port resource, such as a memory port, a writeback bus or a functional unit. It guarantees one transfer per cycle throughput and starvation-free service.

## Interface

- NUM_BITS, default 32, payload width per requester and at the output.

- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- req_val  in  4  per-requester valid; bit i belongs to requester i.
- req_data0..req_data3  in  NUM_BITS each  payload of requester 0..3.
- req_rdy  out  4  per-requester ready; transfer for requester i when req_val[i] && req_rdy[i].
- out_val  out  1  output register holds a transaction.
- out_data  out  NUM_BITS  payload of the held transaction.
- out_src  out  2  index of the requester whose payload is held.
- out_rdy  in  1  consumer ready; output transfer when out_val && out_rdy.

## Operation

- State:
  - Output register: out_val, out_data, out_src.
  - Priority pointer prio[1:0], which names the highest-priority requester this cycle.
- Load enable: load_en = !out_val || out_rdy. The register is empty or is draining this cycle.
- Winner selection (combinational):
  - Scan req_val starting at prio and continue upward modulo 4: prio, prio+1, prio+2, prio+3.
  - The first set bit wins.
  - any_req = |req_val.
- req_rdy[i] = load_en && any_req && (winner == i). At most one bit of req_rdy is set.
- Requesters must not drop req_val or change req_data while waiting. The arbiter does not check this.
- On a clock edge with load_en && any_req:
  - out_data <= req_data[winner], selected through the 4:1 select.
  - out_src <= winner.
  - out_val <= 1.
  - prio <= winner + 1, modulo 4 (3 wraps to 0).
- On a clock edge with load_en && !any_req: out_val <= 0. out_data, out_src and prio hold.
- On a clock edge with !load_en: all state holds. This is backpressure.
- Simultaneous drain and load (out_val && out_rdy && any_req): the old entry leaves and the new winner loads on the same edge. out_val stays 1.
- Fairness: a requester that holds req_val continuously is granted within at most 4 accepted transfers.
- No lock or hold mode. A grant covers exactly one transfer.

## Timing

- Reset (rst_n low, async): out_val=0, out_data=0, out_src=0, prio=0. req_rdy evaluates to 0 while reset is held only if req_val=0. req_rdy is purely combinational from state and req_val. The bench must drive req_val=0 during reset.
- Reset mid-operation: a held transaction is discarded and prio returns to 0. No transfer completes on the edge where reset asserts.
- Latency: 1 cycle. A request accepted at edge N appears on out_val/out_data after edge N.
- Throughput: 1 transfer per cycle when out_rdy is held at 1.
- Combinational paths:
  - req_val -> req_rdy.
  - out_rdy -> req_rdy.
  - No path from req_data to any output.
- Output signals out_val, out_data and out_src are registered and change only on clk edges or on reset.

## Test plan

- Reset: assert rst_n=0 mid-stream with out_val=1 -> out_val=0, out_data=0, out_src=0 immediately. First grant after release with req_val=4'b1111 goes to requester 0.
- Full contention: req_val=4'b1111, out_rdy=1, data_i=32'hA0+i -> out_src sequence 0,1,2,3,0 on consecutive cycles. out_data is 32'hA0..32'hA3. out_val stays 1 throughout.
- Backpressure: out_val=1 holding src 2, out_rdy=0 for 3 cycles with req_val=4'b1011 -> req_rdy=0 throughout, out_data and out_src stable. After out_rdy=1, winner is 3 (prio=3), then 0.
- Sparse and wrap: from prio=0, req_val=4'b0100 -> grant 2 and prio becomes 3. Next req_val=4'b1010 -> grant 3 and prio wraps to 0. Next cycle grant 1.
- Idle drain: single request from requester 1, then req_val=0 with out_rdy=1 -> out_val falls to 0 one cycle after the transfer. out_data holds its last value and prio=2.
- Starvation bound: requester 0 holds req_val, while requesters 1–3 toggle randomly for 1000 cycles with out_rdy=1 -> every wait for requester 0 is at most 4 accepts.

Source files
------------

// File: rtl/dl_rr_arb4.sv
// Four-requester round-robin arbiter feeding a single-entry registered output stage.
// Rotating priority starts at prio_q; the winner's payload loads whenever the stage is empty or draining.
module dl_rr_arb4 #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req_val,
  input  logic [NUM_BITS-1:0] req_data0,
  input  logic [NUM_BITS-1:0] req_data1,
  input  logic [NUM_BITS-1:0] req_data2,
  input  logic [NUM_BITS-1:0] req_data3,
  output logic [3:0]          req_rdy,
  output logic                out_val,
  output logic [NUM_BITS-1:0] out_data,
  output logic [1:0]          out_src,
  input  logic                out_rdy
);

  logic                out_val_q,  out_val_d;
  logic [NUM_BITS-1:0] out_data_q, out_data_d;
  logic [1:0]          out_src_q,  out_src_d;
  logic [1:0]          prio_q,     prio_d;

  logic                load_en;
  logic                any_req;
  logic [1:0]          winner;
  logic [NUM_BITS-1:0] win_data;

  assign load_en = !out_val_q || out_rdy;
  assign any_req = |req_val;

  // Scan upward from prio_q, wrapping mod 4; the first valid requester wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    winner = prio_q;
    found  = 1'b0;
    idx    = prio_q;
    for (int k = 0; k < 4; k++) begin
      idx = prio_q + 2'(k);
      if (!found && req_val[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    case (winner)
      2'd0:    win_data = req_data0;
      2'd1:    win_data = req_data1;
      2'd2:    win_data = req_data2;
      default: win_data = req_data3;
    endcase
  end

  assign req_rdy = (load_en && any_req) ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    prio_d     = prio_q;
    if (load_en) begin
      out_val_d = any_req;
      if (any_req) begin
        out_data_d = win_data;
        out_src_d  = winner;
        prio_d     = winner + 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= 2'd0;
      prio_q     <= 2'd0;
    end else begin
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      prio_q     <= prio_d;
    end
  end

  assign out_val  = out_val_q;
  assign out_data = out_data_q;
  assign out_src  = out_src_q;

endmodule
